// File: rtl/pipeline_stall_ctrl_if.sv
// Stall/flush control bus between the pipeline and its stall scheduler.
// master: pipeline side (raises requests, consumes hold/flush/redirect controls).
// slave:  scheduler side (consumes requests, drives controls and status).
interface pipeline_stall_ctrl_if #(
    parameter int STAGES     = 6,
    parameter int CNT_WIDTH  = 6,
    parameter int PERF_WIDTH = 32
);
    logic                  id_stall_request;
    logic                  ex_start;
    logic [CNT_WIDTH-1:0]  ex_cycles;
    logic                  flush_request;
    logic [31:0]           flush_target;
    logic [STAGES-1:0]     stall;
    logic                  flush;
    logic [31:0]           new_pc;
    logic                  ex_busy;
    logic                  protocol_error;
    logic [PERF_WIDTH-1:0] stall_cycles;

    modport master (
        output id_stall_request,
        output ex_start,
        output ex_cycles,
        output flush_request,
        output flush_target,
        input  stall,
        input  flush,
        input  new_pc,
        input  ex_busy,
        input  protocol_error,
        input  stall_cycles
    );

    modport slave (
        input  id_stall_request,
        input  ex_start,
        input  ex_cycles,
        input  flush_request,
        input  flush_target,
        output stall,
        output flush,
        output new_pc,
        output ex_busy,
        output protocol_error,
        output stall_cycles
    );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush scheduler: merges load-use, multi-cycle EX and flush requests.
// Ports: clock, reset (async active-low), bus (slave side of pipeline_stall_ctrl_if).
module pipeline_stall_ctrl #(
    parameter int STAGES     = 6,
    parameter int CNT_WIDTH  = 6,
    parameter int PERF_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    pipeline_stall_ctrl_if.slave  bus
);
    localparam logic [STAGES-1:0] EX_HOLD = STAGES'(4'b1111);
    localparam logic [STAGES-1:0] ID_HOLD = STAGES'(3'b111);
    localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);

    typedef enum logic {RUN, EX_WAIT} state_t;

    state_t                state;
    logic [CNT_WIDTH-1:0]  count;
    logic                  perr;
    logic [PERF_WIDTH-1:0] cycles;

    logic                  ex_hold;
    logic                  ex_launch;
    logic [STAGES-1:0]     stall_c;
    logic                  flush_c;
    logic [31:0]           pc_c;

    // A multi-cycle op only launches from RUN; 0/1-cycle ops never stall.
    assign ex_launch = (state == RUN) && bus.ex_start && (bus.ex_cycles > ONE);

    always_comb begin
        ex_hold = 1'b0;
        stall_c = '0;
        flush_c = 1'b0;
        pc_c    = '0;
        // Held reset forces every control low whatever the inputs do.
        if (reset) begin
            if (bus.flush_request) begin
                flush_c = 1'b1;
                pc_c    = bus.flush_target;
            end else begin
                if (state == EX_WAIT) begin
                    ex_hold = (count > ONE);
                end else begin
                    ex_hold = ex_launch;
                end
                if (ex_hold) begin
                    stall_c = stall_c | EX_HOLD;
                end
                if (bus.id_stall_request) begin
                    stall_c = stall_c | ID_HOLD;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= RUN;
            count  <= '0;
            perr   <= 1'b0;
            cycles <= '0;
        end else begin
            if ((stall_c != '0) && (cycles != '1)) begin
                cycles <= cycles + PERF_WIDTH'(1);
            end
            if (bus.flush_request) begin
                state <= RUN;
                count <= '0;
            end else begin
                unique case (state)
                    RUN: begin
                        if (ex_launch) begin
                            state <= EX_WAIT;
                            count <= bus.ex_cycles - ONE;
                        end
                    end
                    EX_WAIT: begin
                        // A second start while busy is dropped but flagged.
                        if (bus.ex_start) begin
                            perr <= 1'b1;
                        end
                        if (count > ONE) begin
                            count <= count - ONE;
                        end else begin
                            state <= RUN;
                            count <= '0;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.stall          = stall_c;
    assign bus.flush          = flush_c;
    assign bus.new_pc         = pc_c;
    assign bus.ex_busy        = (state == EX_WAIT);
    assign bus.protocol_error = perr;
    assign bus.stall_cycles   = cycles;
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed table-driven bench for pipeline_stall_ctrl plus reset/saturation sequences.
// A second instance with a 4-bit perf counter shares the same stimulus.
module tb_pipeline_stall_ctrl;
    logic clock;
    logic reset;

    pipeline_stall_ctrl_if #(.STAGES(6), .CNT_WIDTH(6), .PERF_WIDTH(32)) m_if ();
    pipeline_stall_ctrl_if #(.STAGES(6), .CNT_WIDTH(6), .PERF_WIDTH(4))  s_if ();

    pipeline_stall_ctrl #(.STAGES(6), .CNT_WIDTH(6), .PERF_WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (m_if.slave)
    );

    pipeline_stall_ctrl #(.STAGES(6), .CNT_WIDTH(6), .PERF_WIDTH(4)) dut_s (
        .clock (clock),
        .reset (reset),
        .bus   (s_if.slave)
    );

    assign s_if.id_stall_request = m_if.id_stall_request;
    assign s_if.ex_start         = m_if.ex_start;
    assign s_if.ex_cycles        = m_if.ex_cycles;
    assign s_if.flush_request    = m_if.flush_request;
    assign s_if.flush_target     = m_if.flush_target;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic        idr;
        logic        xs;
        logic [5:0]  xc;
        logic        fr;
        logic [31:0] ft;
        logic [5:0]  st;
        logic        fl;
        logic [31:0] pc;
        logic        busy;
        logic        perr;
        logic [31:0] cyc;
    } vec_t;

    vec_t tbl [24];
    int   nvec;
    int   nerr;

    task automatic drive(input logic idr, input logic xs, input logic [5:0] xc,
                         input logic fr, input logic [31:0] ft);
        m_if.id_stall_request = idr;
        m_if.ex_start         = xs;
        m_if.ex_cycles        = xc;
        m_if.flush_request    = fr;
        m_if.flush_target     = ft;
    endtask

    task automatic check(input string name, input logic [5:0] st, input logic fl,
                         input logic [31:0] pc, input logic busy, input logic perr,
                         input logic [31:0] cyc);
        nvec++;
        if (m_if.stall !== st || m_if.flush !== fl || m_if.new_pc !== pc ||
            m_if.ex_busy !== busy || m_if.protocol_error !== perr ||
            m_if.stall_cycles !== cyc) begin
            nerr++;
            $display("FAIL %s: got stall=%b flush=%b pc=%h busy=%b perr=%b cyc=%0d, want stall=%b flush=%b pc=%h busy=%b perr=%b cyc=%0d",
                     name, m_if.stall, m_if.flush, m_if.new_pc, m_if.ex_busy,
                     m_if.protocol_error, m_if.stall_cycles, st, fl, pc, busy, perr, cyc);
        end
    endtask

    task automatic check_small(input string name, input logic [3:0] cyc);
        nvec++;
        if (s_if.stall_cycles !== cyc) begin
            nerr++;
            $display("FAIL %s: got stall_cycles=%0d, want %0d", name, s_if.stall_cycles, cyc);
        end
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        //          idr  xs   xc  fr   ft            stall      fl  pc            busy perr cyc
        tbl[0]  = '{1'b1, 1'b0, 6'd0, 1'b0, 32'h0, 6'b000111, 1'b0, 32'h0, 1'b0, 1'b0, 32'd0};
        tbl[1]  = '{1'b1, 1'b0, 6'd0, 1'b0, 32'h0, 6'b000111, 1'b0, 32'h0, 1'b0, 1'b0, 32'd1};
        tbl[2]  = '{1'b1, 1'b0, 6'd0, 1'b0, 32'h0, 6'b000111, 1'b0, 32'h0, 1'b0, 1'b0, 32'd2};
        tbl[3]  = '{1'b0, 1'b0, 6'd0, 1'b0, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0, 32'd3};
        tbl[4]  = '{1'b0, 1'b1, 6'd4, 1'b0, 32'h0, 6'b001111, 1'b0, 32'h0, 1'b0, 1'b0, 32'd3};
        tbl[5]  = '{1'b0, 1'b0, 6'd0, 1'b0, 32'h0, 6'b001111, 1'b0, 32'h0, 1'b1, 1'b0, 32'd4};
        tbl[6]  = '{1'b0, 1'b0, 6'd0, 1'b0, 32'h0, 6'b001111, 1'b0, 32'h0, 1'b1, 1'b0, 32'd5};
        tbl[7]  = '{1'b0, 1'b0, 6'd0, 1'b0, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b1, 1'b0, 32'd6};
        tbl[8]  = '{1'b0, 1'b0, 6'd0, 1'b0, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0, 32'd6};
        tbl[9]  = '{1'b0, 1'b1, 6'd5, 1'b0, 32'h0, 6'b001111, 1'b0, 32'h0, 1'b0, 1'b0, 32'd6};
        tbl[10] = '{1'b0, 1'b0, 6'd0, 1'b0, 32'h0, 6'b001111, 1'b0, 32'h0, 1'b1, 1'b0, 32'd7};
        tbl[11] = '{1'b0, 1'b0, 6'd0, 1'b1, 32'h100, 6'b000000, 1'b1, 32'h100, 1'b1, 1'b0, 32'd8};
        tbl[12] = '{1'b0, 1'b0, 6'd0, 1'b0, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0, 32'd8};
        tbl[13] = '{1'b0, 1'b1, 6'd1, 1'b0, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0, 32'd8};
        tbl[14] = '{1'b0, 1'b1, 6'd0, 1'b0, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0, 32'd8};
        tbl[15] = '{1'b0, 1'b0, 6'd0, 1'b0, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0, 32'd8};
        tbl[16] = '{1'b1, 1'b1, 6'd4, 1'b0, 32'h0, 6'b001111, 1'b0, 32'h0, 1'b0, 1'b0, 32'd8};
        tbl[17] = '{1'b1, 1'b0, 6'd0, 1'b0, 32'h0, 6'b001111, 1'b0, 32'h0, 1'b1, 1'b0, 32'd9};
        tbl[18] = '{1'b1, 1'b1, 6'd4, 1'b0, 32'h0, 6'b001111, 1'b0, 32'h0, 1'b1, 1'b0, 32'd10};
        tbl[19] = '{1'b1, 1'b0, 6'd0, 1'b0, 32'h0, 6'b000111, 1'b0, 32'h0, 1'b1, 1'b1, 32'd11};
        tbl[20] = '{1'b1, 1'b0, 6'd0, 1'b0, 32'h0, 6'b000111, 1'b0, 32'h0, 1'b0, 1'b1, 32'd12};
        tbl[21] = '{1'b0, 1'b0, 6'd0, 1'b0, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0, 1'b1, 32'd13};
        tbl[22] = '{1'b1, 1'b1, 6'd3, 1'b1, 32'hDEADBEEF, 6'b000000, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 32'd13};
        tbl[23] = '{1'b0, 1'b0, 6'd0, 1'b0, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0, 1'b1, 32'd13};

        drive(1'b0, 1'b0, 6'd0, 1'b0, 32'h0);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 24; i++) begin
            @(negedge clock);
            drive(tbl[i].idr, tbl[i].xs, tbl[i].xc, tbl[i].fr, tbl[i].ft);
            #2;
            check($sformatf("vec%0d", i), tbl[i].st, tbl[i].fl, tbl[i].pc,
                  tbl[i].busy, tbl[i].perr, tbl[i].cyc);
        end

        // Held reset overrides active requests and clears sticky/perf state.
        @(negedge clock);
        drive(1'b1, 1'b1, 6'd4, 1'b1, 32'h1234_5678);
        reset = 1'b0;
        #2;
        check("reset_hold", 6'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'd0);
        @(negedge clock);
        drive(1'b0, 1'b0, 6'd0, 1'b0, 32'h0);
        reset = 1'b1;

        // Perf counter: 4-bit instance saturates at 15, 32-bit one keeps counting.
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            drive(1'b1, 1'b0, 6'd0, 1'b0, 32'h0);
            #2;
            if (i == 14) check_small("sat_14", 4'd14);
        end
        @(negedge clock);
        drive(1'b0, 1'b0, 6'd0, 1'b0, 32'h0);
        #2;
        check_small("sat_15", 4'd15);
        check("perf_20", 6'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'd20);

        // Asynchronous reset in the middle of an EX_WAIT sequence.
        @(negedge clock);
        drive(1'b0, 1'b1, 6'd6, 1'b0, 32'h0);
        #2;
        check("abort_start", 6'b001111, 1'b0, 32'h0, 1'b0, 1'b0, 32'd20);
        @(negedge clock);
        drive(1'b0, 1'b0, 6'd0, 1'b0, 32'h0);
        #2;
        check("abort_wait", 6'b001111, 1'b0, 32'h0, 1'b1, 1'b0, 32'd21);
        drive(1'b1, 1'b0, 6'd0, 1'b0, 32'h0);
        reset = 1'b0;
        #1;
        check("abort_async", 6'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'd0);
        check_small("abort_small", 4'd0);
        @(negedge clock);
        drive(1'b0, 1'b0, 6'd0, 1'b0, 32'h0);
        reset = 1'b1;
        #2;
        check("release_0", 6'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'd0);
        @(negedge clock);
        #2;
        check("release_1", 6'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
